// File: rtl/dfp_sig_align_seq.sv
// Multi-cycle decimal significand aligner: right-shifts the smaller-exponent
// BCD operand by up to STEP digits per cycle, producing guard digits and sticky.
module dfp_sig_align_seq #(
   parameter int unsigned DIGITS  = 7,
   parameter int unsigned GUARD   = 3,
   parameter int unsigned SHAMT_W = 8,
   parameter int unsigned STEP    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   m1,
   input  logic [4*DIGITS-1:0]   m2,
   input  logic [SHAMT_W-1:0]    r,
   input  logic                  greater,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   m1_norm,
   output logic [4*DIGITS-1:0]   m2_norm,
   output logic [4*GUARD-1:0]    grs,
   output logic                  sticky
);

   localparam int unsigned TOT   = DIGITS + GUARD;
   localparam int unsigned SIG_W = 4 * DIGITS;
   localparam int unsigned GRS_W = 4 * GUARD;
   localparam int unsigned SR_W  = 4 * TOT;
   localparam int unsigned REM_W = $clog2(TOT + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t            state, state_nx;
   logic [SR_W-1:0]   sr_q, sr_nx;
   logic [SIG_W-1:0]  keep_q;
   logic              sel_q;
   logic [REM_W-1:0]  rem_q, rem_nx, rem_ld, step_k;
   logic              stk_q, stk_nx;

   // Clamp the requested shift to the full significand+guard window.
   always_comb begin
      rem_ld = '0;
      if (64'(r) >= 64'(TOT))
         rem_ld = REM_W'(TOT);
      else
         rem_ld = REM_W'(r);
   end

   always_comb begin
      sr_nx  = sr_q;
      stk_nx = stk_q;
      for (int unsigned i = 0; i < STEP; i++) begin
         if (REM_W'(i) < rem_q) begin
            stk_nx = stk_nx | (|sr_nx[3:0]);
            sr_nx  = sr_nx >> 4;
         end
      end
      step_k = (rem_q > REM_W'(STEP)) ? REM_W'(STEP) : rem_q;
      rem_nx = rem_q - step_k;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_nx = (rem_ld != '0) ? SHIFT : DONE;
         end
         SHIFT: begin
            if (rem_nx == '0)
               state_nx = DONE;
         end
         DONE: begin
            if (out_valid && out_ready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // DONE spends its first cycle loading the output registers, so out_valid
   // trails the last shift by one edge and the outputs are pure flops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr_q      <= '0;
         keep_q    <= '0;
         sel_q     <= 1'b0;
         rem_q     <= '0;
         stk_q     <= 1'b0;
         out_valid <= 1'b0;
         m1_norm   <= '0;
         m2_norm   <= '0;
         grs       <= '0;
         sticky    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sr_q   <= {(greater ? m2 : m1), {GRS_W{1'b0}}};
                  keep_q <= greater ? m1 : m2;
                  sel_q  <= greater;
                  stk_q  <= 1'b0;
                  rem_q  <= rem_ld;
               end
            end
            SHIFT: begin
               sr_q  <= sr_nx;
               stk_q <= stk_nx;
               rem_q <= rem_nx;
            end
            DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  m1_norm   <= sel_q ? keep_q : sr_q[SR_W-1 -: SIG_W];
                  m2_norm   <= sel_q ? sr_q[SR_W-1 -: SIG_W] : keep_q;
                  grs       <= sr_q[GRS_W-1:0];
                  sticky    <= stk_q;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dfp_sig_align_seq.sv
// Scoreboard bench for dfp_sig_align_seq: STEP=2, 1 and 10 instances share
// stimulus; each has its own expected-result queue and monitor.
module tb_dfp_sig_align_seq;

   localparam int DIG  = 7;
   localparam int GRD  = 3;
   localparam int TOT  = DIG + GRD;
   localparam int SW   = 4 * DIG;
   localparam int GW   = 4 * GRD;

   typedef struct {
      logic [SW-1:0] m1n;
      logic [SW-1:0] m2n;
      logic [GW-1:0] grs;
      logic          st;
      int            s;
      int            acc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          out_ready;
   logic [SW-1:0] m1, m2;
   logic [7:0]    r;
   logic          greater;

   logic [2:0]    ir, ov, stk;
   logic [SW-1:0] m1n [3];
   logic [SW-1:0] m2n [3];
   logic [GW-1:0] grs [3];

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   exp_t q0[$], q1[$], q2[$];
   logic [2:0] seen = '0;
   logic [2:0] hold = '0;
   exp_t mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dfp_sig_align_seq #(.DIGITS(DIG), .GUARD(GRD), .SHAMT_W(8), .STEP(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
      .m1(m1), .m2(m2), .r(r), .greater(greater),
      .out_valid(ov[0]), .out_ready(out_ready),
      .m1_norm(m1n[0]), .m2_norm(m2n[0]), .grs(grs[0]), .sticky(stk[0]));

   dfp_sig_align_seq #(.DIGITS(DIG), .GUARD(GRD), .SHAMT_W(8), .STEP(1)) u_step1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
      .m1(m1), .m2(m2), .r(r), .greater(greater),
      .out_valid(ov[1]), .out_ready(out_ready),
      .m1_norm(m1n[1]), .m2_norm(m2n[1]), .grs(grs[1]), .sticky(stk[1]));

   dfp_sig_align_seq #(.DIGITS(DIG), .GUARD(GRD), .SHAMT_W(8), .STEP(10)) u_step10 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
      .m1(m1), .m2(m2), .r(r), .greater(greater),
      .out_valid(ov[2]), .out_ready(out_ready),
      .m1_norm(m1n[2]), .m2_norm(m2n[2]), .grs(grs[2]), .sticky(stk[2]));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      n_total++;
      if (act === want)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
   endtask

   function automatic int step_of(input int d);
      case (d)
         0:       return 2;
         1:       return 1;
         default: return 10;
      endcase
   endfunction

   function automatic int qsz(input int d);
      case (d)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic exp_t qfront(input int d);
      case (d)
         0:       return q0[0];
         1:       return q1[0];
         default: return q2[0];
      endcase
   endfunction

   task automatic qpop(input int d);
      case (d)
         0:       void'(q0.pop_front());
         1:       void'(q1.pop_front());
         default: void'(q2.pop_front());
      endcase
   endtask

   function automatic exp_t mk(input logic [SW-1:0] a, input logic [SW-1:0] b,
                               input logic [GW-1:0] g, input logic st, input int s);
      exp_t e;
      e.m1n = a; e.m2n = b; e.grs = g; e.st = st; e.s = s; e.acc = 0;
      return e;
   endfunction

   // Reference: result digit j takes source digit j+s; digits below s feed sticky.
   function automatic exp_t model(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                  input logic [7:0] rr, input logic g);
      exp_t e;
      logic [3:0] src [TOT];
      logic [3:0] dst [TOT];
      logic [SW-1:0] sel;
      logic [SW-1:0] sig;
      logic [GW-1:0] gd;
      int s;
      s = (int'(rr) > TOT) ? TOT : int'(rr);
      sel = g ? b : a;
      e.st = 1'b0;
      for (int j = 0; j < TOT; j++)
         src[j] = (j < GRD) ? 4'h0 : sel[4*(j-GRD) +: 4];
      for (int j = 0; j < TOT; j++) begin
         dst[j] = (j + s < TOT) ? src[j+s] : 4'h0;
         if (j < s && src[j] != 4'h0) e.st = 1'b1;
      end
      for (int j = 0; j < GRD; j++) gd[4*j +: 4] = dst[j];
      for (int j = 0; j < DIG; j++) sig[4*j +: 4] = dst[j+GRD];
      e.m1n = g ? a : sig;
      e.m2n = g ? sig : b;
      e.grs = gd;
      e.s   = s;
      e.acc = 0;
      return e;
   endfunction

   // Monitor: latency check on out_valid rise, data check on handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         q0.delete(); q1.delete(); q2.delete();
         seen = '0;
         hold = '0;
      end else begin
         for (int d = 0; d < 3; d++) begin
            if (hold[d])
               chk($sformatf("hold_valid[%0d]", d), 64'(ov[d]), 64'(1));
            if (ov[d] && !seen[d]) begin
               seen[d] = 1'b1;
               if (qsz(d) == 0) begin
                  n_total++;
                  $display("FAIL spurious_valid[%0d]: got out_valid=1 expected no result", d);
               end else begin
                  mon_e = qfront(d);
                  chk($sformatf("latency[%0d]", d), 64'(cyc - mon_e.acc),
                      64'(1 + (mon_e.s + step_of(d) - 1) / step_of(d)));
               end
            end
            if (ov[d] && out_ready) begin
               if (qsz(d) > 0) begin
                  mon_e = qfront(d);
                  qpop(d);
                  chk($sformatf("m1_norm[%0d]", d), 64'(m1n[d]), 64'(mon_e.m1n));
                  chk($sformatf("m2_norm[%0d]", d), 64'(m2n[d]), 64'(mon_e.m2n));
                  chk($sformatf("grs[%0d]", d),     64'(grs[d]), 64'(mon_e.grs));
                  chk($sformatf("sticky[%0d]", d),  64'(stk[d]), 64'(mon_e.st));
               end
               seen[d] = 1'b0;
            end
            hold[d] = ov[d] && !out_ready;
         end
      end
   end

   task automatic issue(input logic [SW-1:0] a, input logic [SW-1:0] b,
                        input logic [7:0] rr, input logic g, input exp_t e);
      int n = 0;
      while (ir !== 3'b111) begin
         @(posedge clk); #1;
         n++;
         if (n > 500) begin
            $display("FAIL issue_timeout: got in_ready=%b expected 111", ir);
            $fatal(1, "in_ready never returned");
         end
      end
      m1 = a; m2 = b; r = rr; greater = g; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      e.acc = cyc;
      q0.push_back(e); q1.push_back(e); q2.push_back(e);
   endtask

   task automatic issue_model(input logic [SW-1:0] a, input logic [SW-1:0] b,
                              input logic [7:0] rr, input logic g);
      issue(a, b, rr, g, model(a, b, rr, g));
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() + q1.size() + q2.size()) != 0 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_pending", 64'(q0.size() + q1.size() + q2.size()), 64'(0));
   endtask

   logic [SW-1:0] c_m1, c_m2;
   logic [GW-1:0] c_grs;
   logic          c_st;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      m1 = '0; m2 = '0; r = '0; greater = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_out_valid", 64'(ov), 64'(0));
      chk("rst_in_ready", 64'(ir), 64'(3'b111));
      chk("rst_m1_norm", 64'(m1n[0]), 64'(0));
      chk("rst_m2_norm", 64'(m2n[0]), 64'(0));
      chk("rst_grs", 64'(grs[0]), 64'(0));
      chk("rst_sticky", 64'(stk), 64'(0));

      // Directed vectors: m1, m2, r, greater, then hand-computed results
      issue(28'h7654321, 28'h1234567, 8'd2, 1'b1, mk(28'h7654321, 28'h0012345, 12'h670, 1'b0, 2));
      issue(28'h1234567, 28'h5555555, 8'd8, 1'b0, mk(28'h0000000, 28'h5555555, 12'h012, 1'b1, 8));
      issue(28'h0987654, 28'h3210000, 8'd0, 1'b1, mk(28'h0987654, 28'h3210000, 12'h000, 1'b0, 0));
      issue(28'h9000001, 28'h1111111, 8'd200, 1'b0, mk(28'h0000000, 28'h1111111, 12'h000, 1'b1, 10));
      issue(28'h0000000, 28'h2222222, 8'd200, 1'b0, mk(28'h0000000, 28'h2222222, 12'h000, 1'b0, 10));
      issue(28'h0000001, 28'h0000001, 8'd10, 1'b1, mk(28'h0000001, 28'h0000000, 12'h000, 1'b1, 10));
      issue(28'h6666666, 28'h1234567, 8'd9, 1'b1, mk(28'h6666666, 28'h0000000, 12'h001, 1'b1, 9));
      issue(28'hFABCDEF, 28'h0000003, 8'd4, 1'b0, mk(28'h0000FAB, 28'h0000003, 12'hCDE, 1'b1, 4));
      drain();

      // Backpressure: results held, in_valid pulses ignored
      out_ready = 1'b0;
      issue(28'h4444444, 28'h8000009, 8'd3, 1'b1, mk(28'h4444444, 28'h0008000, 12'h009, 1'b0, 3));
      for (int n = 0; n < 20 && ov !== 3'b111; n++) begin
         @(posedge clk); #1;
      end
      chk("bp_all_valid", 64'(ov), 64'(3'b111));
      c_m1 = m1n[0]; c_m2 = m2n[0]; c_grs = grs[0]; c_st = stk[0];
      for (int n = 0; n < 5; n++) begin
         in_valid = n[0] ? 1'b0 : 1'b1;
         m1 = 28'h9999999; m2 = 28'h9999999; r = 8'd1; greater = 1'b0;
         @(posedge clk); #1;
         chk("bp_out_valid", 64'(ov[0]), 64'(1));
         chk("bp_in_ready", 64'(ir), 64'(0));
         chk("bp_m2_stable", 64'(m2n[0]), 64'(c_m2));
         chk("bp_m1_stable", 64'(m1n[0]), 64'(c_m1));
         chk("bp_grs_stable", 64'({c_st, grs[0]}), 64'({stk[0], c_grs}));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();

      // Reset while the STEP=2 instance is mid-shift
      out_ready = 1'b0;
      issue(28'h1111111, 28'h1234567, 8'd9, 1'b1, mk(28'h0, 28'h0, 12'h0, 1'b0, 9));
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_out_valid", 64'(ov), 64'(0));
      chk("abort_in_ready", 64'(ir), 64'(3'b111));
      chk("abort_m1_norm", 64'(m1n[0]), 64'(0));
      chk("abort_m2_norm", 64'(m2n[0]), 64'(0));
      chk("abort_grs", 64'(grs[0]), 64'(0));
      out_ready = 1'b1;
      issue(28'h1234567, 28'h7777777, 8'd1, 1'b0, mk(28'h0123456, 28'h7777777, 12'h700, 1'b0, 1));
      drain();

      // Back-to-back random operands against the digit model
      for (int n = 0; n < 40; n++) begin
         logic [SW-1:0] a, b;
         logic [7:0]    rr;
         a  = SW'($urandom);
         b  = SW'($urandom);
         rr = (n % 8 == 7) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
         issue_model(a, b, rr, 1'($urandom));
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule
